result_writeback_unit: RTL
==========================

// Module: result_writeback_unit
// PURPOSE
//  Drains the output result FIFO, which sits directly upstream, into a local result memory.
//  After start it pops one result at a time whenever the FIFO is non-empty.
//  It writes each result to sequential addresses and raises done after NUM_RESULTS writes.
//  The stored results are then read out through a registered host port.
// PARAMETERS
//  DATA_WIDTH   16  width of one result word
//  NUM_RESULTS  16  results per run; number of memory entries (>=2)
//  ADDR_WIDTH   4   memory address width; 2**ADDR_WIDTH >= NUM_RESULTS
// PORTS
//  clk                 in   1           rising-edge clock
//  rst                 in   1           synchronous, active-high reset
//  start               in   1           1-cycle pulse; begins a run (ignored while busy)
//  buf_empty           in   1           upstream FIFO empty flag
//  buf_dout            in   DATA_WIDTH  upstream FIFO read data
//  read_buffer_result  out  1           upstream FIFO read enable (1-cycle pulse)
//  host_raddr          in   ADDR_WIDTH  host read address
//  host_rdata          out  DATA_WIDTH  host read data (registered)
//  result_count        out  ADDR_WIDTH+1  results written in current/last run
//  busy                out  1           high in READ/WAIT
//  done                out  1           high in DONE until the next start or rst
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge):
//    - state=IDLE; all outputs 0; wr_addr=0; all memory entries cleared to 0.
//  - FIFO contract: buf_dout is valid the cycle after read_buffer_result is sampled high.
//  - FSM states: IDLE, READ, WAIT, DONE.
//    - IDLE: start=1 -> READ; wr_addr=0, result_count=0, done=0.
//    - READ: if !buf_empty, drive read_buffer_result=1 for one cycle -> WAIT. Else hold READ.
//      read_buffer_result is never asserted while buf_empty=1 or outside READ.
//    - WAIT: write buf_dout to mem[wr_addr]; increment wr_addr and result_count.
//      If the new count == NUM_RESULTS -> DONE, else -> READ.
//    - DONE: done=1. start=1 -> READ with counters cleared and done=0 the next cycle.
//      Memory is not cleared on restart.
//  - Throughput: max 1 result per 2 cycles.
//    Latency: start -> first read_buffer_result = 1 cycle when the FIFO is non-empty.
//  - start during READ/WAIT is ignored; there is no abort other than rst.
//  - buf_empty toggling mid-run only stalls READ; count and address are preserved.
//  - wr_addr never exceeds NUM_RESULTS-1; it returns to 0 only on a new start.
//  - Host port: host_rdata <= mem[host_raddr] every cycle (1-cycle latency).
//    host_raddr >= NUM_RESULTS returns 0.
//    Same-cycle write and read of one address returns the old value.
//  - rst mid-run: back to IDLE next cycle, no further FIFO reads, memory cleared.
//    An in-flight WAIT write is dropped.
//  - Stored words are the raw DATA_WIDTH bits unless RELU_EN is defined; no width change.
// CONFIGURATION
//  Macro: RESULT_WRITEBACK_RELU_EN
//  - Defined: the value written in WAIT is 0 if buf_dout[DATA_WIDTH-1]=1
//    (two's-complement negative), else buf_dout.
//  - Undefined: buf_dout is written unmodified. Timing and FSM are identical either way.
// TESTING
//  1. rst 2 cycles -> busy=0, done=0, read_buffer_result=0, result_count=0, host_rdata=0.
//  2. FIFO preloaded with 1..16, start pulse -> 16 reads spaced 2 cycles apart;
//     done=1 after 32 cycles; result_count=16; host_raddr=5 -> host_rdata=6 one cycle later.
//  3. buf_empty=1 for 10 cycles after 3rd result -> no read_buffer_result while empty;
//     result_count holds 3; run then completes with values in order.
//  4. rst asserted in WAIT at 7th result -> IDLE next cycle; busy=0, done=0;
//     no further reads; mem[6] reads 0.
//  5. start during busy -> ignored (count unaffected).
//     start in DONE -> second run overwrites entries; result_count restarts at 0.
//  6. RELU_EN on: push 16'hFFF0 and 16'h0012 -> stored 0 and 16'h0012.
//     RELU_EN off: stored 16'hFFF0 and 16'h0012.

Source files
------------

// File: rtl/result_writeback_unit_if.sv
// Handshake and host-port bundle for result_writeback_unit.
// The master side drives the upstream FIFO status/data, start and host read
// address; the slave side (the writeback unit) returns the FIFO read strobe,
// host read data and run status.
interface result_writeback_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_dout;
    logic                  read_buffer_result;
    logic [ADDR_WIDTH-1:0] host_raddr;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic [ADDR_WIDTH:0]   result_count;
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output buf_empty,
        output buf_dout,
        output host_raddr,
        input  read_buffer_result,
        input  host_rdata,
        input  result_count,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  buf_empty,
        input  buf_dout,
        input  host_raddr,
        output read_buffer_result,
        output host_rdata,
        output result_count,
        output busy,
        output done
    );
endinterface

// File: rtl/result_writeback_unit.sv
// result_writeback_unit
// Drains the upstream result FIFO into a local result memory, one word every
// two cycles, and raises done after NUM_RESULTS writes. Stored words are read
// back through a registered host port.
// Optional feature macro: RESULT_WRITEBACK_RELU_EN -- when defined, negative
// (two's-complement) words are stored as zero; timing is unchanged.
module result_writeback_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_RESULTS = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    result_writeback_unit_if.slave        bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(NUM_RESULTS);

    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_inc_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_req_s;
    logic                  start_ok_s;
    logic [DATA_WIDTH-1:0] host_rdata_r;
    logic [DATA_WIDTH-1:0] mem_r [0:NUM_RESULTS-1];

    // Value actually committed to memory for one popped FIFO word.
    function automatic logic [DATA_WIDTH-1:0] wb_value(input logic [DATA_WIDTH-1:0] d);
`ifdef RESULT_WRITEBACK_RELU_EN
        if (d[DATA_WIDTH-1]) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return d;
        end
`else
        return d;
`endif
    endfunction

    // FIFO pop request: must be combinational so the FIFO sees it in the READ
    // cycle and presents data during WAIT; reset suppresses it immediately.
    always_comb begin
        rd_req_s    = (state_r == ST_READ) && !bus.buf_empty && !rst;
        start_ok_s  = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        count_inc_s = count_r + (ADDR_WIDTH+1)'(1'b1);
    end

    // Next-state decode for the drain sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_req_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WAIT: begin
                if (count_inc_s == FULL_COUNT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_READ) || (state_s == ST_WAIT);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Write address and result count; the address saturates at the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            count_r   <= {(ADDR_WIDTH+1){1'b0}};
        end else if (start_ok_s) begin
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            count_r   <= {(ADDR_WIDTH+1){1'b0}};
        end else if (state_r == ST_WAIT) begin
            count_r <= count_inc_s;
            if (count_inc_s != FULL_COUNT) begin
                wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1'b1);
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end else begin
            wr_addr_r <= wr_addr_r;
            count_r   <= count_r;
        end
    end

    // Result memory: cleared by reset, written once per WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (state_r == ST_WAIT) begin
            mem_r[wr_addr_r] <= wb_value(bus.buf_dout);
        end
    end

    // Registered host read; addresses past the last entry read as zero and a
    // same-cycle write to the read address returns the previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if ({1'b0, bus.host_raddr} < FULL_COUNT) begin
            host_rdata_r <= mem_r[bus.host_raddr];
        end else begin
            host_rdata_r <= {DATA_WIDTH{1'b0}};
        end
    end

    assign bus.read_buffer_result = rd_req_s;
    assign bus.host_rdata         = host_rdata_r;
    assign bus.result_count       = count_r;
    assign bus.busy               = busy_r;
    assign bus.done               = done_r;

endmodule
